cmd_seq: RTL and testbench
==========================

CMD_SEQ -- requirements
Module: cmd_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of script entries (2..64).
REQ-002 SHALL have parameter TMO_W, default 24, width of the per-step response timeout counter.
REQ-003 SHALL have parameter ACK, default 8'hA5, the expected positive response byte.
REQ-004 SHALL have port clk  in  1  system clock; the single clock, all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports wr_en/wr_addr/wr_cmd/wr_wait  in  1/$clog2(DEPTH)/16/1  script write port; wr_wait=1 means the step waits for a response.
REQ-007 SHALL have ports start/len  in  1/$clog2(DEPTH)+1  run request and the number of steps to execute (1..DEPTH).
REQ-008 SHALL have ports tmo_lim  in  TMO_W  timeout limit in clocks.
REQ-009 SHALL have ports cmd/snd_cmd  out  16/1  command to the UART command sender and a 1-clock send strobe.
REQ-010 SHALL have port cmd_snt  in  1  1-clock pulse when the command has been fully transmitted.
REQ-011 SHALL have ports resp_rdy/resp  in  1/8  response valid flag and data; clr_resp_rdy  out  1  1-clock clear pulse.
REQ-012 SHALL have outputs busy, done (1-clk pulse), err (level), err_code[1:0], step[$clog2(DEPTH)-1:0].

Function
REQ-013 SHALL implement states IDLE, SEND, WAIT_SNT, WAIT_RESP, NEXT, FIN, ERR.
REQ-014 IDLE: start with len in 1..DEPTH loads step=0 and enters SEND; start with len=0 or len>DEPTH enters ERR with err_code=2'b11.
REQ-015 SEND SHALL drive cmd=script[step] and pulse snd_cmd for exactly one clock, then enter WAIT_SNT; cmd holds its value until the next SEND.
REQ-016 WAIT_SNT: on cmd_snt, enter WAIT_RESP if wr_wait was set for the step, else NEXT; the timeout counter clears on entry to WAIT_RESP.
REQ-017 WAIT_RESP: resp_rdy with resp==ACK pulses clr_resp_rdy and enters NEXT; resp_rdy with resp!=ACK pulses clr_resp_rdy and enters ERR with err_code=2'b01.
REQ-018 WAIT_RESP: the counter reaching tmo_lim with no resp_rdy enters ERR with err_code=2'b10; resp_rdy in that same clock takes priority over the timeout.
REQ-019 NEXT: if step==len-1 enter FIN, else increment step and enter SEND; step never wraps past len-1.
REQ-020 FIN SHALL pulse done for one clock and return to IDLE.
REQ-021 ERR SHALL hold err=1 until the next start, which clears err and err_code and restarts from step 0.
REQ-022 busy SHALL be 1 in every state except IDLE and ERR.
REQ-023 start while busy SHALL be ignored.
REQ-024 Script writes SHALL be accepted in any state; a write to the executing entry takes effect at the next SEND of that entry.
REQ-025 resp_rdy outside WAIT_RESP SHALL be ignored and not cleared.

Reset
REQ-026 rst SHALL force IDLE, step=0, cmd=16'h0000, snd_cmd=0, clr_resp_rdy=0, busy=0, done=0, err=0, err_code=0 and clear the timeout counter, including when asserted mid-run.
REQ-027 Script storage SHALL NOT be reset.

Configuration
REQ-028 With CMD_SEQ_RETRY_EN defined, a timeout SHALL re-enter SEND for the same step up to 2 times before entering ERR, and a per-step retry count SHALL clear in NEXT.
REQ-029 Without CMD_SEQ_RETRY_EN, the first timeout SHALL enter ERR.

Structure
REQ-030 The state enum, err_code encodings, and the default ACK value SHALL live in package cmd_seq_pkg.
REQ-031 The timeout counter SHALL be a sub-module seq_tmr (clear, enable, limit, expired).

Verification
REQ-032 Calibrate-then-tour: script {16'h2000 wait, 16'h6000 wait}, len=2, ACK returned 100 clks after each cmd_snt -> two snd_cmd pulses in order, done once, err=0.
REQ-033 Negative response: resp=8'h5A at step 0 -> err=1, err_code=01, step=0, no second snd_cmd.
REQ-034 Timeout: tmo_lim=1000, no response -> err_code=10 exactly 1000 clks after WAIT_RESP entry; with CMD_SEQ_RETRY_EN, 3 snd_cmd pulses precede err.
REQ-035 No-wait steps: len=3, all wr_wait=0 -> done after the third cmd_snt; clr_resp_rdy never pulses.
REQ-036 Reset mid-run: rst asserted during WAIT_RESP of step 1 -> all outputs at reset values next clock; a new start runs from step 0.
REQ-037 Boundary: len=0 -> err_code=11; len=DEPTH -> all DEPTH entries sent; start while busy -> no effect.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// Shared types and encodings for the command sequencer.
package cmd_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_SNT,
    S_WAIT_RESP,
    S_NEXT,
    S_FIN,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_NAK  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_LEN  = 2'b11;

  localparam logic [7:0] ACK_DEFAULT = 8'hA5;

  localparam int RETRY_MAX = 2;

endpackage

// File: rtl/cmd_seq_tmr.sv
// Response timeout counter; expired fires in the cycle whose clock edge makes the count reach limit.
module seq_tmr #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Saturates so a huge limit can never alias back to a small count.
  always_ff @(posedge clk) begin
    if (clear)                      cnt <= '0;
    else if (enable && cnt != '1)   cnt <= cnt + 1'b1;
  end

  assign expired = enable && (({1'b0, cnt} + 1'b1) >= {1'b0, limit});

endmodule

// File: rtl/cmd_seq.sv
// Scripted UART command sequencer: sends stored commands, optionally waits for ACK per step.
// Define CMD_SEQ_RETRY_EN to retry a timed-out step up to twice before failing.
module cmd_seq
  import cmd_seq_pkg::*;
#(
  parameter int         DEPTH = 8,
  parameter int         TMO_W = 24,
  parameter logic [7:0] ACK   = ACK_DEFAULT,
  localparam int        AW    = $clog2(DEPTH),
  localparam int        LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [15:0]      wr_cmd,
  input  logic             wr_wait,
  input  logic             start,
  input  logic [LW-1:0]    len,
  input  logic [TMO_W-1:0] tmo_lim,
  output logic [15:0]      cmd,
  output logic             snd_cmd,
  input  logic             cmd_snt,
  input  logic             resp_rdy,
  input  logic [7:0]       resp,
  output logic             clr_resp_rdy,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [AW-1:0]    step
);

  state_t           state;
  logic [15:0]      cmd_mem [DEPTH];
  logic [DEPTH-1:0] wait_mem;
  logic [LW-1:0]    len_q;
  logic             wait_q;
  logic             len_ok, last_step;
  logic             tmr_clr, tmr_en, tmr_exp;
`ifdef CMD_SEQ_RETRY_EN
  logic [1:0]       retry_cnt;
`endif

  // Script storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      cmd_mem[wr_addr]  <= wr_cmd;
      wait_mem[wr_addr] <= wr_wait;
    end
  end

  assign len_ok    = (len != '0) && (len <= LW'(DEPTH));
  assign last_step = ({1'b0, step} == (len_q - 1'b1));
  assign busy      = (state != S_IDLE) && (state != S_ERR);
  assign tmr_clr   = rst || (state == S_WAIT_SNT && cmd_snt && wait_q);
  assign tmr_en    = (state == S_WAIT_RESP);

  seq_tmr #(.W(TMO_W)) u_tmr (
    .clk     (clk),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .limit   (tmo_lim),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      step         <= '0;
      cmd          <= 16'h0000;
      snd_cmd      <= 1'b0;
      clr_resp_rdy <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      len_q        <= '0;
      wait_q       <= 1'b0;
`ifdef CMD_SEQ_RETRY_EN
      retry_cnt    <= '0;
`endif
    end else begin
      snd_cmd      <= 1'b0;
      clr_resp_rdy <= 1'b0;
      done         <= 1'b0;
      unique case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
            step     <= '0;
            len_q    <= len;
`ifdef CMD_SEQ_RETRY_EN
            retry_cnt <= '0;
`endif
            if (len_ok) begin
              state <= S_SEND;
            end else begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_LEN;
            end
          end
        end
        // Entry is read here so a rewrite of the running step lands on its next send.
        S_SEND: begin
          cmd     <= cmd_mem[step];
          wait_q  <= wait_mem[step];
          snd_cmd <= 1'b1;
          state   <= S_WAIT_SNT;
        end
        S_WAIT_SNT: begin
          if (cmd_snt) state <= wait_q ? S_WAIT_RESP : S_NEXT;
        end
        S_WAIT_RESP: begin
          if (resp_rdy) begin
            clr_resp_rdy <= 1'b1;
            if (resp == ACK) begin
              state <= S_NEXT;
            end else begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_NAK;
            end
          end else if (tmr_exp) begin
`ifdef CMD_SEQ_RETRY_EN
            if (retry_cnt < 2'(RETRY_MAX)) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_SEND;
            end else begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_TMO;
            end
`else
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= ERR_TMO;
`endif
          end
        end
        S_NEXT: begin
`ifdef CMD_SEQ_RETRY_EN
          retry_cnt <= '0;
`endif
          if (last_step) begin
            state <= S_FIN;
            done  <= 1'b1;
          end else begin
            step  <= step + 1'b1;
            state <= S_SEND;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_seq.sv
// Scoreboard bench for cmd_seq: directed runs push expected output events, a monitor pops them.
module tb_cmd_seq;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  localparam logic [1:0] EV_SND  = 2'd0;
  localparam logic [1:0] EV_CLR  = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;
  localparam logic [1:0] EV_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, wr_wait, start, cmd_snt, resp_rdy;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_cmd;
  logic [AW:0]   len;
  logic [23:0]   tmo_lim;
  logic [7:0]    resp;
  logic [15:0]   cmd;
  logic          snd_cmd, clr_resp_rdy, busy, done, err;
  logic [1:0]    err_code;
  logic [AW-1:0] step;

  ev_t expq[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  logic err_d;

  always #5 clk = ~clk;

  cmd_seq #(.DEPTH(DEPTH), .TMO_W(24), .ACK(8'hA5)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_cmd(wr_cmd), .wr_wait(wr_wait),
    .start(start), .len(len), .tmo_lim(tmo_lim),
    .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt),
    .resp_rdy(resp_rdy), .resp(resp), .clr_resp_rdy(clr_resp_rdy),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .step(step)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    expq.push_back(e);
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [15:0] d);
    ev_t e;
    n_tests++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL event: got kind=%0d data=%h, required none", k, d);
    end else begin
      e = expq.pop_front();
      if (e.kind !== k || e.data !== d) begin
        n_fail++;
        $display("FAIL event: got kind=%0d data=%h, required kind=%0d data=%h",
                 k, d, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every DUT output event must match the head of the expected queue.
  initial begin
    err_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (snd_cmd)       expect_ev(EV_SND, cmd);
        if (clr_resp_rdy)  expect_ev(EV_CLR, 16'h0);
        if (done)          expect_ev(EV_DONE, 16'h0);
        if (err && !err_d) expect_ev(EV_ERR, 16'({step, err_code}));
      end
      err_d = err;
    end
  end

  function automatic logic sel(input int w);
    case (w)
      0:       return snd_cmd;
      1:       return done;
      2:       return err;
      3:       return clr_resp_rdy;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input string name, input int lim);
    int i;
    i = 0;
    while (!sel(w) && i < lim) begin
      @(negedge clk);
      i++;
    end
    if (!sel(w)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no event in %0d clks, required one", name, lim);
    end
  endtask

  task automatic write_entry(input int a, input logic [15:0] c, input logic w);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_cmd  = c;
    wr_wait = w;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_run(input int l);
    start = 1'b1;
    len   = (AW+1)'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_snt();
    cmd_snt = 1'b1;
    @(negedge clk);
    cmd_snt = 1'b0;
  endtask

  task automatic give_resp(input logic [7:0] v, input int dly);
    repeat (dly) @(negedge clk);
    resp     = v;
    resp_rdy = 1'b1;
    @(negedge clk);
    wait_for(3, "clr_resp_rdy", 20);
    resp_rdy = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_cmd = '0; wr_wait = 1'b0;
    start = 1'b0; len = '0; tmo_lim = 24'd5000; cmd_snt = 1'b0;
    resp_rdy = 1'b0; resp = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst step", step, 0);
    chk("rst cmd", cmd, 16'h0000);
    chk("rst snd_cmd", snd_cmd, 0);
    chk("rst clr_resp_rdy", clr_resp_rdy, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst err_code", err_code, 0);
    rst = 1'b0;
    @(negedge clk);

    // Two waited steps, ACK 100 clocks after each send; a start mid-run is ignored.
    write_entry(0, 16'h2000, 1'b1);
    write_entry(1, 16'h6000, 1'b1);
    push(EV_SND, 16'h2000); push(EV_CLR, 0);
    push(EV_SND, 16'h6000); push(EV_CLR, 0); push(EV_DONE, 0);
    start_run(2);
    chk("cal busy", busy, 1);
    wait_for(0, "cal snd0", 50);
    start_run(1);
    pulse_snt();
    give_resp(8'hA5, 100);
    wait_for(0, "cal snd1", 50);
    chk("cal step1", step, 1);
    pulse_snt();
    give_resp(8'hA5, 100);
    wait_for(1, "cal done", 50);
    chk("cal err", err, 0);
    @(negedge clk);
    chk("cal idle busy", busy, 0);

    // Negative response on step 0.
    push(EV_SND, 16'h2000); push(EV_CLR, 0); push(EV_ERR, 16'({3'd0, 2'b01}));
    start_run(2);
    wait_for(0, "nak snd0", 50);
    pulse_snt();
    give_resp(8'h5A, 5);
    chk("nak err", err, 1);
    chk("nak err_code", err_code, 2'b01);
    chk("nak step", step, 0);
    repeat (20) @(negedge clk);
    chk("nak busy", busy, 0);

    // Timeout with no response; start from ERR clears the error.
    tmo_lim = 24'd1000;
`ifdef CMD_SEQ_RETRY_EN
    push(EV_SND, 16'h2000); push(EV_SND, 16'h2000);
`endif
    push(EV_SND, 16'h2000); push(EV_ERR, 16'({3'd0, 2'b10}));
    start_run(2);
    chk("tmo err cleared", err, 0);
    chk("tmo code cleared", err_code, 0);
`ifdef CMD_SEQ_RETRY_EN
    repeat (2) begin
      wait_for(0, "tmo retry snd", 1100);
      pulse_snt();
    end
`endif
    wait_for(0, "tmo snd", 1100);
    pulse_snt();
    k = 0;
    while (!err && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("tmo latency", k, 1000);
    chk("tmo err_code", err_code, 2'b10);
    tmo_lim = 24'd5000;

    // No-wait steps with a stale resp_rdy held high: it must never be cleared.
    write_entry(0, 16'h1111, 1'b0);
    write_entry(1, 16'h2222, 1'b0);
    write_entry(2, 16'h3333, 1'b0);
    resp = 8'hA5;
    resp_rdy = 1'b1;
    push(EV_SND, 16'h1111); push(EV_SND, 16'h2222); push(EV_SND, 16'h3333);
    push(EV_DONE, 0);
    start_run(3);
    repeat (3) begin
      wait_for(0, "nowait snd", 50);
      pulse_snt();
    end
    wait_for(1, "nowait done", 20);
    resp_rdy = 1'b0;
    @(negedge clk);

    // Reset while waiting for the response of step 1.
    write_entry(0, 16'h2000, 1'b1);
    write_entry(1, 16'h6000, 1'b1);
    push(EV_SND, 16'h2000); push(EV_CLR, 0); push(EV_SND, 16'h6000);
    start_run(2);
    wait_for(0, "mid snd0", 50);
    pulse_snt();
    give_resp(8'hA5, 3);
    wait_for(0, "mid snd1", 50);
    pulse_snt();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst step", step, 0);
    chk("mid rst cmd", cmd, 16'h0000);
    chk("mid rst busy", busy, 0);
    chk("mid rst err", err, 0);
    chk("mid rst snd_cmd", snd_cmd, 0);
    rst = 1'b0;
    @(negedge clk);
    push(EV_SND, 16'h2000); push(EV_CLR, 0); push(EV_DONE, 0);
    start_run(1);
    wait_for(0, "post rst snd", 50);
    chk("post rst step", step, 0);
    pulse_snt();
    give_resp(8'hA5, 3);
    wait_for(1, "post rst done", 20);
    @(negedge clk);

    // Length boundaries.
    push(EV_ERR, 16'({3'd0, 2'b11}));
    start_run(0);
    wait_for(2, "len0 err", 10);
    chk("len0 err_code", err_code, 2'b11);
    chk("len0 busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(EV_ERR, 16'({3'd0, 2'b11}));
    start_run(DEPTH + 1);
    wait_for(2, "len9 err", 10);
    chk("len9 err_code", err_code, 2'b11);

    for (int i = 0; i < DEPTH; i++) begin
      write_entry(i, 16'hA000 + 16'(i), 1'b0);
      push(EV_SND, 16'hA000 + 16'(i));
    end
    push(EV_DONE, 0);
    start_run(DEPTH);
    chk("full err cleared", err, 0);
    for (int i = 0; i < DEPTH; i++) begin
      wait_for(0, "full snd", 50);
      pulse_snt();
    end
    wait_for(1, "full done", 20);
    @(negedge clk);
    chk("full busy", busy, 0);

    repeat (5) @(negedge clk);
    chk("events left", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, required finish");
    $fatal(1);
  end

endmodule
